// File: rtl/fios_pkg.sv
// Shared encodings for the 3A FIOS cascade: DSP OPMODEs, operand
// mux selects and the controller state set.
package fios_pkg;

  localparam logic [6:0] OP_ZERO   = 7'b0000000;
  localparam logic [6:0] OP_M      = 7'b0000101;
  localparam logic [6:0] OP_M_C    = 7'b0110101;
  localparam logic [6:0] OP_M_PCIN = 7'b0010101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MUXA_AREG = 2'd0,
    MUXA_RES  = 2'd1,
    MUXA_MREG = 2'd2
  } mux_a_e;

  typedef enum logic [1:0] {
    MUXB_B  = 2'd0,
    MUXB_P0 = 2'd1,
    MUXB_P  = 2'd2
  } mux_b_e;

  typedef enum logic [1:0] {
    MUXC_CI   = 2'd0,
    MUXC_RESD = 2'd1
  } mux_c_e;

  typedef struct packed {
    logic       a_reg_en;
    logic       m_reg_en;
    mux_a_e     sel_a;
    mux_b_e     sel_b;
    mux_c_e     sel_c;
    logic       creg_en;
    logic       resd_en;
    logic [6:0] opmode;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    a_reg_en: 1'b0,
    m_reg_en: 1'b0,
    sel_a:    MUXA_AREG,
    sel_b:    MUXB_B,
    sel_c:    MUXC_CI,
    creg_en:  1'b0,
    resd_en:  1'b0,
    opmode:   OP_ZERO
  };

endpackage

// File: rtl/fios_phase_cnt.sv
// Outer-iteration / phase counter pair for the FIOS sequencer.
// Exposes next-cycle values so the owner can register its decode.
module fios_phase_cnt #(
  parameter int S = 16,
  parameter int P = 9
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 en,
  output logic [$clog2(S)-1:0] i_nxt,
  output logic [$clog2(P)-1:0] c_nxt,
  output logic                 last_iter,
  output logic                 last_phase
);

  localparam int IW = $clog2(S);
  localparam int CW = $clog2(P);

  logic [IW-1:0] i_q;
  logic [CW-1:0] c_q;

  assign last_iter  = (i_q == IW'(S - 1));
  assign last_phase = (c_q == CW'(P - 1));

  always_comb begin
    i_nxt = i_q;
    c_nxt = c_q;
    if (en) begin
      if (last_phase) begin
        c_nxt = '0;
        i_nxt = last_iter ? '0 : i_q + IW'(1);
      end else begin
        c_nxt = c_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      i_q <= '0;
      c_q <= '0;
    end else begin
      i_q <= i_nxt;
      c_q <= c_nxt;
    end
  end

endmodule

// File: rtl/fios_ctrl_casc_3a.sv
// Control sequencer for the head PE of a cascaded 3A FIOS chain.
// Outputs are decoded from next-cycle state and registered.
module fios_ctrl_casc_3a
  import fios_pkg::*;
#(
  parameter int S      = 16,
  parameter int NUM_PE = S,
  parameter int ABREG  = 1,
  parameter int MREG   = 1
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [$clog2(S)-1:0] a_word_idx_o,
  output logic                 a_reg_en_o,
  output logic                 m_reg_en_o,
  output logic [1:0]           mux_A_sel_o,
  output logic [1:0]           mux_B_sel_o,
  output logic [1:0]           mux_C_sel_o,
  output logic                 CREG_en_o,
  output logic                 RES_delay_en_o,
  output logic [6:0]           OPMODE_o
);

  localparam int L     = 1 + ABREG + MREG;
  localparam int P     = 2 * L + 3;
  localparam int DRAIN = L + NUM_PE;
  localparam int IW    = $clog2(S);
  localparam int CW    = $clog2(P);
  localparam int DW    = $clog2(DRAIN + 1);

  localparam logic [CW-1:0] PH_AREG = CW'(0);
  localparam logic [CW-1:0] PH_AB   = CW'(1);
  localparam logic [CW-1:0] PH_M    = CW'(1 + L);
  localparam logic [CW-1:0] PH_MCAP = CW'(1 + 2 * L);
  localparam logic [CW-1:0] PH_MP   = CW'(2 + 2 * L);

  state_e        st_q, st_nxt;
  logic [DW-1:0] d_q, d_nxt;
  logic          cnt_en;
  logic          last_iter, last_phase;
  logic [IW-1:0] i_nxt;
  logic [CW-1:0] c_nxt;

  ctrl_t         ctl_q, ctl_nxt;
  logic [IW-1:0] idx_q, idx_nxt;
  logic          busy_q, busy_nxt;
  logic          done_q, done_nxt;

  fios_phase_cnt #(
    .S(S),
    .P(P)
  ) u_cnt (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .en         (cnt_en),
    .i_nxt      (i_nxt),
    .c_nxt      (c_nxt),
    .last_iter  (last_iter),
    .last_phase (last_phase)
  );

  always_comb begin
    st_nxt = st_q;
    d_nxt  = d_q;
    cnt_en = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (start_i) st_nxt = ST_RUN;
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (last_iter && last_phase) begin
          st_nxt = ST_DRAIN;
          d_nxt  = '0;
        end
      end
      ST_DRAIN: begin
        d_nxt = d_q + DW'(1);
        if (d_q == DW'(DRAIN - 1)) st_nxt = ST_DONE;
      end
      ST_DONE: st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  // The a*b0 issue of the first iteration has no partial sum to add.
  always_comb begin
    ctl_nxt  = CTRL_IDLE;
    idx_nxt  = '0;
    busy_nxt = (st_nxt == ST_RUN) || (st_nxt == ST_DRAIN);
    done_nxt = (st_nxt == ST_DONE);
    if (st_nxt == ST_RUN) begin
      idx_nxt = i_nxt;
      unique case (1'b1)
        (c_nxt == PH_AREG): ctl_nxt.a_reg_en = 1'b1;
        (c_nxt == PH_AB): begin
          ctl_nxt.sel_a   = MUXA_AREG;
          ctl_nxt.sel_b   = MUXB_B;
          ctl_nxt.sel_c   = MUXC_RESD;
          ctl_nxt.creg_en = 1'b1;
          ctl_nxt.opmode  = (i_nxt == '0) ? OP_M : OP_M_C;
        end
        (c_nxt == PH_M): begin
          ctl_nxt.sel_a  = MUXA_RES;
          ctl_nxt.sel_b  = MUXB_P0;
          ctl_nxt.opmode = OP_M;
        end
        (c_nxt == PH_MCAP): ctl_nxt.m_reg_en = 1'b1;
        (c_nxt == PH_MP): begin
          ctl_nxt.sel_a   = MUXA_MREG;
          ctl_nxt.sel_b   = MUXB_P;
          ctl_nxt.sel_c   = MUXC_RESD;
          ctl_nxt.opmode  = OP_M_C;
          ctl_nxt.creg_en = 1'b1;
          ctl_nxt.resd_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      st_q   <= ST_IDLE;
      d_q    <= '0;
      ctl_q  <= CTRL_IDLE;
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_nxt;
      d_q    <= d_nxt;
      ctl_q  <= ctl_nxt;
      idx_q  <= idx_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign a_word_idx_o   = idx_q;
  assign a_reg_en_o     = ctl_q.a_reg_en;
  assign m_reg_en_o     = ctl_q.m_reg_en;
  assign mux_A_sel_o    = ctl_q.sel_a;
  assign mux_B_sel_o    = ctl_q.sel_b;
  assign mux_C_sel_o    = ctl_q.sel_c;
  assign CREG_en_o      = ctl_q.creg_en;
  assign RES_delay_en_o = ctl_q.resd_en;
  assign OPMODE_o       = ctl_q.opmode;

endmodule

// File: tb/tb_fios_ctrl_casc_3a.sv
// Scoreboard bench for fios_ctrl_casc_3a: two instances, one with
// S=4/L=3 and one with the minimal S=2/L=1 configuration.
module tb_fios_ctrl_casc_3a;

  localparam logic [6:0] OPZ  = 7'b0000000;
  localparam logic [6:0] OPM  = 7'b0000101;
  localparam logic [6:0] OPMC = 7'b0110101;

  localparam int K_AREG = 0;
  localparam int K_ISS  = 1;
  localparam int K_MREG = 2;
  localparam int K_DONE = 3;
  localparam int K_MISS = 4;

  typedef struct {
    int         cyc;
    int         kind;
    logic [6:0] op;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] sc;
    logic       rd;
    int         idx;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  ev_t q0[$];
  ev_t q1[$];

  logic       rst0, start0, busy0, done0, aen0, men0, creg0, rd0;
  logic [1:0] idx0, sa0, sb0, sc0;
  logic [6:0] op0;
  logic       rst1, start1, busy1, done1, aen1, men1, creg1, rd1;
  logic [0:0] idx1;
  logic [1:0] sa1, sb1, sc1;
  logic [6:0] op1;

  fios_ctrl_casc_3a #(
    .S(4), .NUM_PE(4), .ABREG(1), .MREG(1)
  ) u_dut0 (
    .clock_i(clk), .reset_i(rst0), .start_i(start0),
    .busy_o(busy0), .done_o(done0), .a_word_idx_o(idx0),
    .a_reg_en_o(aen0), .m_reg_en_o(men0),
    .mux_A_sel_o(sa0), .mux_B_sel_o(sb0), .mux_C_sel_o(sc0),
    .CREG_en_o(creg0), .RES_delay_en_o(rd0), .OPMODE_o(op0)
  );

  fios_ctrl_casc_3a #(
    .S(2), .NUM_PE(2), .ABREG(0), .MREG(0)
  ) u_dut1 (
    .clock_i(clk), .reset_i(rst1), .start_i(start1),
    .busy_o(busy1), .done_o(done1), .a_word_idx_o(idx1),
    .a_reg_en_o(aen1), .m_reg_en_o(men1),
    .mux_A_sel_o(sa1), .mux_B_sel_o(sb1), .mux_C_sel_o(sc1),
    .CREG_en_o(creg1), .RES_delay_en_o(rd1), .OPMODE_o(op1)
  );

  function automatic ev_t mk(input int c, input int k,
                             input logic [6:0] op,
                             input logic [1:0] sa,
                             input logic [1:0] sb,
                             input logic [1:0] sc,
                             input logic rd, input int idx);
    ev_t e;
    e.cyc = c; e.kind = k; e.op = op;
    e.sa = sa; e.sb = sb; e.sc = sc;
    e.rd = rd; e.idx = idx;
    return e;
  endfunction

  task automatic push(input int w, input ev_t e, input int rel,
                      input int cut);
    if (rel <= cut) begin
      if (w == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  // Expected strobe timeline of one run whose start is sampled at
  // the edge closing cycle t0; events after t0+cut are dropped.
  task automatic expect_run(input int w, input int t0, input int s,
                            input int l, input int done_rel,
                            input int cut);
    int p;
    int b;
    p = 2 * l + 3;
    for (int i = 0; i < s; i++) begin
      b = 1 + i * p;
      push(w, mk(t0 + b, K_AREG, OPZ, 0, 0, 0, 0, i), b, cut);
      push(w, mk(t0 + b + 1, K_ISS, (i == 0) ? OPM : OPMC,
                 0, 0, 1, 0, i), b + 1, cut);
      push(w, mk(t0 + b + 1 + l, K_MISS, OPM, 1, 1, 0, 0, i),
           b + 1 + l, cut);
      push(w, mk(t0 + b + 1 + 2 * l, K_MREG, OPZ, 0, 0, 0, 0, i),
           b + 1 + 2 * l, cut);
      push(w, mk(t0 + b + 2 + 2 * l, K_ISS, OPMC, 2, 2, 1, 1, i),
           b + 2 + 2 * l, cut);
    end
    push(w, mk(t0 + done_rel, K_DONE, OPZ, 0, 0, 0, 0, 0),
         done_rel, cut);
  endtask

  task automatic check_ev(input int w, input string nm, input ev_t g);
    ev_t e;
    tests++;
    if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
      fails++;
      $display("FAIL %s unexpected event k%0d at cyc=%0d, want none",
               nm, g.kind, g.cyc);
    end else begin
      e = (w == 0) ? q0.pop_front() : q1.pop_front();
      if (e.cyc != g.cyc || e.kind != g.kind || e.op !== g.op ||
          e.sa !== g.sa || e.sb !== g.sb || e.sc !== g.sc ||
          e.rd !== g.rd || e.idx != g.idx) begin
        fails++;
        $display({"FAIL %s got cyc=%0d k%0d op=%b a=%0d b=%0d c=%0d",
                  " rd=%0d i=%0d, want cyc=%0d k%0d op=%b a=%0d",
                  " b=%0d c=%0d rd=%0d i=%0d"},
                 nm, g.cyc, g.kind, g.op, g.sa, g.sb, g.sc, g.rd,
                 g.idx, e.cyc, e.kind, e.op, e.sa, e.sb, e.sc, e.rd,
                 e.idx);
      end
    end
  endtask

  always @(negedge clk) begin
    if (aen0 === 1'b1)
      check_ev(0, "d0_areg", mk(cyc, K_AREG, op0, sa0, sb0, sc0, rd0, int'(idx0)));
    if (creg0 === 1'b1)
      check_ev(0, "d0_iss", mk(cyc, K_ISS, op0, sa0, sb0, sc0, rd0, int'(idx0)));
    if (sa0 === 2'd1)
      check_ev(0, "d0_miss", mk(cyc, K_MISS, op0, sa0, sb0, sc0, rd0, int'(idx0)));
    if (men0 === 1'b1)
      check_ev(0, "d0_mreg", mk(cyc, K_MREG, op0, sa0, sb0, sc0, rd0, int'(idx0)));
    if (done0 === 1'b1) begin
      check_ev(0, "d0_done", mk(cyc, K_DONE, op0, sa0, sb0, sc0, rd0, int'(idx0)));
      tests++;
      if (busy0 !== 1'b0) begin
        fails++;
        $display("FAIL d0_busy_at_done got %b want 0", busy0);
      end
    end
  end

  always @(negedge clk) begin
    if (aen1 === 1'b1)
      check_ev(1, "d1_areg", mk(cyc, K_AREG, op1, sa1, sb1, sc1, rd1, int'(idx1)));
    if (creg1 === 1'b1)
      check_ev(1, "d1_iss", mk(cyc, K_ISS, op1, sa1, sb1, sc1, rd1, int'(idx1)));
    if (sa1 === 2'd1)
      check_ev(1, "d1_miss", mk(cyc, K_MISS, op1, sa1, sb1, sc1, rd1, int'(idx1)));
    if (men1 === 1'b1)
      check_ev(1, "d1_mreg", mk(cyc, K_MREG, op1, sa1, sb1, sc1, rd1, int'(idx1)));
    if (done1 === 1'b1) begin
      check_ev(1, "d1_done", mk(cyc, K_DONE, op1, sa1, sb1, sc1, rd1, int'(idx1)));
      tests++;
      if (busy1 !== 1'b0) begin
        fails++;
        $display("FAIL d1_busy_at_done got %b want 0", busy1);
      end
    end
  end

  task automatic tick_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk_zero0(input string nm);
    logic [21:0] v;
    v = {busy0, done0, idx0, aen0, men0, sa0, sb0, sc0, creg0, rd0, op0};
    tests++;
    if (v !== '0) begin
      fails++;
      $display("FAIL %s outputs got %b want all 0", nm, v);
    end
  endtask

  task automatic chk_zero1(input string nm);
    logic [20:0] v;
    v = {busy1, done1, idx1, aen1, men1, sa1, sb1, sc1, creg1, rd1, op1};
    tests++;
    if (v !== '0) begin
      fails++;
      $display("FAIL %s outputs got %b want all 0", nm, v);
    end
  endtask

  task automatic chk_bit(input string nm, input logic got,
                         input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %b want %b", nm, got, want);
    end
  endtask

  task automatic chk_empty(input string nm, input int n);
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL %s pending expected events got %0d want 0", nm, n);
    end
  endtask

  initial begin
    int t0;
    rst0 = 1'b1; rst1 = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero0("d0_reset");
    chk_zero1("d1_reset");
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk_zero0("d0_idle");

    // full run with ignored start pulses mid-run
    t0 = cyc;
    expect_run(0, t0, 4, 3, 44, 1000);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk_bit("d0_busy_c1", busy0, 1'b1);
    tick_to(t0 + 5);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    tick_to(t0 + 20);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    tick_to(t0 + 43);
    chk_bit("d0_busy_drain", busy0, 1'b1);
    tick_to(t0 + 45);
    chk_bit("d0_busy_after", busy0, 1'b0);
    tick_to(t0 + 50);
    chk_empty("d0_run1", q0.size());

    // abort with reset, then restart
    t0 = cyc;
    expect_run(0, t0, 4, 3, 44, 15);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    tick_to(t0 + 15);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    chk_zero0("d0_abort");
    chk_empty("d0_abort_q", q0.size());
    tick_to(t0 + 17);
    expect_run(0, t0 + 17, 4, 3, 44, 1000);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    tick_to(t0 + 62);
    chk_bit("d0_restart_idle", busy0, 1'b0);
    chk_empty("d0_restart_q", q0.size());

    // reset and start together: reset wins
    rst0 = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    start0 = 1'b0;
    chk_zero0("d0_rst_start");
    repeat (3) @(negedge clk);
    chk_bit("d0_rst_start_idle", busy0, 1'b0);

    // minimal configuration S=2, L=1
    t0 = cyc;
    expect_run(1, t0, 2, 1, 14, 1000);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk_bit("d1_busy_c1", busy1, 1'b1);
    tick_to(t0 + 20);
    chk_zero1("d1_idle_after");
    chk_empty("d1_run_q", q1.size());
    chk_empty("d0_final_q", q0.size());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
